matvec_mult_lanes: RTL and testbench

Parametrised successor to the single-row matrix-vector multiplier: computes y = W·x for a runtime-sized matrix using NUM_LANES row accumulators in parallel, each consuming BANDWIDTH elements per beat. It adds ragged-edge masking, saturating accumulation, an optional fixed-point rescale of results, and a valid/ready result stream with backpressure. It sits between the matrix loader (request/response port) and the LSTM gate logic (result consumer).

---
 rtl/matvec_pkg.sv | 36 +++
 rtl/matvec_mult_lanes_mac_lane.sv | 59 +++++
 rtl/matvec_mult_lanes.sv | 242 ++++++++++++++++++++++++
 tb/tb_matvec_mult_lanes.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types and arithmetic helpers for matvec_mult_lanes
// Contents: controller state enum, wide calculation type, accumulator
// saturation and fixed-point rescale functions used by the top and lanes.
package matvec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Working width for dot products and rescale; comfortably wider than any
  // accumulator plus one beat of BANDWIDTH products for 16-bit data.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Clamp v into the signed range of a w-bit value.
  function automatic calc_t sat_acc(input calc_t v, input int w);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Round-half-up, drop frac fractional bits, clamp to a w-bit signed value.
  function automatic calc_t rescale_sat(input calc_t v, input int frac, input int w);
    calc_t t;
    t = (v + (calc_t'(1) <<< (frac - 1))) >>> frac;
    return sat_acc(t, w);
  endfunction

endpackage

// File: rtl/matvec_mult_lanes_mac_lane.sv
// rtl/matvec_mult_lanes_mac_lane.sv - one row lane: masked dot product and saturating accumulator
// Ports: clk/rst, clear (zero accumulator), enable (add one beat),
// row_data/vec_data (BANDWIDTH elements, element 0 in LSBs), col_base and
// num_cols (columns at or beyond num_cols contribute zero), acc (result).
module mac_lane
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BANDWIDTH  = 16,
  parameter int COL_W      = 8,
  parameter int NC_W       = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                enable,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0]     row_data,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0]     vec_data,
  input  logic [COL_W-1:0]                    col_base,
  input  logic [NC_W-1:0]                     num_cols,
  output logic signed [2*DATA_WIDTH-1:0]      acc
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      acc_d;
  logic signed [DATA_WIDTH-1:0] w_e;
  logic signed [DATA_WIDTH-1:0] x_e;
  calc_t                        dot;

  always_comb begin
    dot = '0;
    w_e = '0;
    x_e = '0;
    for (int i = 0; i < BANDWIDTH; i++) begin
      if (int'(col_base) + i < int'(num_cols)) begin
        w_e = row_data[i*DATA_WIDTH +: DATA_WIDTH];
        x_e = vec_data[i*DATA_WIDTH +: DATA_WIDTH];
        dot = dot + calc_t'(w_e) * calc_t'(x_e);
      end
    end
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      // Whole beat summed at full width, saturated once per beat.
      acc_d = ACC_W'(sat_acc(calc_t'(acc_q) + dot, ACC_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matvec_mult_lanes.sv
// rtl/matvec_mult_lanes.sv - y = W*x with NUM_LANES parallel row accumulators
// Ports: start/num_rows/num_cols/result_scale configure a run;
// vector_write_enable/vector_base_addr/vector_in load x in IDLE;
// matrix_enable/matrix_addr/matrix_data/matrix_ready fetch W beats;
// result_out/result_row/result_valid/result_ready stream results;
// busy, done and cfg_error report status.
module matvec_mult_lanes
  import matvec_pkg::*;
#(
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int BANDWIDTH  = 16,
  parameter int NUM_LANES  = 2,
  parameter int FRAC_BITS  = 12
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [$clog2(MAX_ROWS):0]                   num_rows,
  input  logic [$clog2(MAX_COLS):0]                   num_cols,
  input  logic                                        result_scale,
  input  logic                                        vector_write_enable,
  input  logic [$clog2(MAX_COLS)-1:0]                 vector_base_addr,
  input  logic [DATA_WIDTH*BANDWIDTH-1:0]             vector_in,
  output logic                                        matrix_enable,
  output logic [$clog2(MAX_ROWS*MAX_COLS)-1:0]        matrix_addr,
  input  logic [NUM_LANES*BANDWIDTH*DATA_WIDTH-1:0]   matrix_data,
  input  logic                                        matrix_ready,
  output logic [2*DATA_WIDTH-1:0]                     result_out,
  output logic [$clog2(MAX_ROWS)-1:0]                 result_row,
  output logic                                        result_valid,
  input  logic                                        result_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        cfg_error
);

  localparam int RW    = $clog2(MAX_ROWS) + 1;
  localparam int CW    = $clog2(MAX_COLS) + 1;
  localparam int RBW   = RW + 1;   // row_base may step past num_rows
  localparam int CBW   = CW + 1;   // col_base may step past num_cols
  localparam int AW    = $clog2(MAX_ROWS * MAX_COLS);
  localparam int VAW   = $clog2(MAX_COLS);
  localparam int ROW_W = $clog2(MAX_ROWS);
  localparam int LIW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ACC_W = 2 * DATA_WIDTH;

  state_e           state_q, state_d;
  logic [RW-1:0]    rows_q, rows_d;
  logic [CW-1:0]    cols_q, cols_d;
  logic             scale_q, scale_d;
  logic [RBW-1:0]   row_base_q, row_base_d;
  logic [CBW-1:0]   col_base_q, col_base_d;
  logic [LIW-1:0]   lane_idx_q, lane_idx_d;
  logic             matrix_enable_q, matrix_enable_d;
  logic [AW-1:0]    matrix_addr_q, matrix_addr_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_error_q, cfg_error_d;

  logic             lane_clear;
  logic             fetch_beat;
  logic             last_lane;
  logic [NUM_LANES-1:0]            lane_en;
  logic signed [ACC_W-1:0]         lane_acc [NUM_LANES];
  logic signed [ACC_W-1:0]         sel_acc;
  logic [DATA_WIDTH*BANDWIDTH-1:0] x_chunk;
  logic [DATA_WIDTH-1:0]           vec_mem [MAX_COLS];
  int                              x_idx;

  // x buffer: deliberately not reset; writable only while idle.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && vector_write_enable) begin
      for (int i = 0; i < BANDWIDTH; i++) begin
        if (int'(vector_base_addr) + i < MAX_COLS)
          vec_mem[VAW'(int'(vector_base_addr) + i)] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    x_chunk = '0;
    x_idx   = 0;
    for (int i = 0; i < BANDWIDTH; i++) begin
      x_idx = int'(col_base_q) + i;
      if (x_idx < MAX_COLS) x_chunk[i*DATA_WIDTH +: DATA_WIDTH] = vec_mem[VAW'(x_idx)];
    end
  end

  assign fetch_beat = (state_q == ST_FETCH) && matrix_ready;
  // Final lane of the group: either the last physical lane or the last row.
  assign last_lane  = (int'(lane_idx_q) == NUM_LANES - 1) ||
                      (int'(row_base_q) + int'(lane_idx_q) + 1 >= int'(rows_q));

  always_comb begin
    state_d         = state_q;
    rows_d          = rows_q;
    cols_d          = cols_q;
    scale_d         = scale_q;
    row_base_d      = row_base_q;
    col_base_d      = col_base_q;
    lane_idx_d      = lane_idx_q;
    matrix_enable_d = matrix_enable_q;
    result_valid_d  = result_valid_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    cfg_error_d     = 1'b0;
    lane_clear      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (int'(num_rows) >= 1 && int'(num_rows) <= MAX_ROWS &&
              int'(num_cols) >= 1 && int'(num_cols) <= MAX_COLS) begin
            rows_d          = num_rows;
            cols_d          = num_cols;
            scale_d         = result_scale;
            row_base_d      = '0;
            col_base_d      = '0;
            lane_idx_d      = '0;
            lane_clear      = 1'b1;
            matrix_enable_d = 1'b1;
            busy_d          = 1'b1;
            state_d         = ST_FETCH;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (matrix_ready) begin
          col_base_d = col_base_q + CBW'(BANDWIDTH);
          if (int'(col_base_q) + BANDWIDTH >= int'(cols_q)) begin
            matrix_enable_d = 1'b0;
            result_valid_d  = 1'b1;
            lane_idx_d      = '0;
            state_d         = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (result_ready) begin
          if (last_lane) begin
            result_valid_d = 1'b0;
            lane_clear     = 1'b1;
            lane_idx_d     = '0;
            col_base_d     = '0;
            row_base_d     = row_base_q + RBW'(NUM_LANES);
            if (int'(row_base_q) + NUM_LANES < int'(rows_q)) begin
              matrix_enable_d = 1'b1;
              state_d         = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end
          end else begin
            lane_idx_d = lane_idx_q + 1'b1;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    matrix_addr_d = AW'(int'(row_base_d) * int'(cols_d) + int'(col_base_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rows_q          <= '0;
      cols_q          <= '0;
      scale_q         <= 1'b0;
      row_base_q      <= '0;
      col_base_q      <= '0;
      lane_idx_q      <= '0;
      matrix_enable_q <= 1'b0;
      matrix_addr_q   <= '0;
      result_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cfg_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rows_q          <= rows_d;
      cols_q          <= cols_d;
      scale_q         <= scale_d;
      row_base_q      <= row_base_d;
      col_base_q      <= col_base_d;
      lane_idx_q      <= lane_idx_d;
      matrix_enable_q <= matrix_enable_d;
      matrix_addr_q   <= matrix_addr_d;
      result_valid_q  <= result_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cfg_error_q     <= cfg_error_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // Lanes past the last row of a ragged group sit idle.
    assign lane_en[l] = fetch_beat && (int'(row_base_q) + l < int'(rows_q));
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .BANDWIDTH  (BANDWIDTH),
      .COL_W      (CBW),
      .NC_W       (CW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (lane_clear),
      .enable   (lane_en[l]),
      .row_data (matrix_data[l*BANDWIDTH*DATA_WIDTH +: BANDWIDTH*DATA_WIDTH]),
      .vec_data (x_chunk),
      .col_base (col_base_q),
      .num_cols (cols_q),
      .acc      (lane_acc[l])
    );
  end

  // Result is a mux of registered accumulators by a registered lane index,
  // so it holds steady for as long as the consumer stalls.
  always_comb begin
    sel_acc = lane_acc[0];
    for (int l = 1; l < NUM_LANES; l++) begin
      if (int'(lane_idx_q) == l) sel_acc = lane_acc[l];
    end
  end

  assign result_out    = scale_q ? ACC_W'(rescale_sat(calc_t'(sel_acc), FRAC_BITS, DATA_WIDTH))
                                 : sel_acc;
  assign result_row    = ROW_W'(int'(row_base_q) + int'(lane_idx_q));
  assign result_valid  = result_valid_q;
  assign matrix_enable = matrix_enable_q;
  assign matrix_addr   = matrix_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_error     = cfg_error_q;

endmodule

// File: tb/tb_matvec_mult_lanes.sv
// tb/tb_matvec_mult_lanes.sv - self-checking bench for matvec_mult_lanes
module tb_matvec_mult_lanes;

  localparam int MR = 64;
  localparam int MC = 64;
  localparam int DW = 16;
  localparam int BW = 16;
  localparam int NL = 2;
  localparam int FB = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [6:0]             num_rows = '0;
  logic [6:0]             num_cols = '0;
  logic                   result_scale = 1'b0;
  logic                   vector_write_enable = 1'b0;
  logic [5:0]             vector_base_addr = '0;
  logic [DW*BW-1:0]       vector_in = '0;
  logic                   matrix_enable;
  logic [11:0]            matrix_addr;
  logic [NL*BW*DW-1:0]    matrix_data;
  logic                   matrix_ready;
  logic [2*DW-1:0]        result_out;
  logic [5:0]             result_row;
  logic                   result_valid;
  logic                   result_ready;
  logic                   busy;
  logic                   done;
  logic                   cfg_error;

  matvec_mult_lanes #(
    .MAX_ROWS(MR), .MAX_COLS(MC), .DATA_WIDTH(DW),
    .BANDWIDTH(BW), .NUM_LANES(NL), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .result_scale(result_scale), .vector_write_enable(vector_write_enable),
    .vector_base_addr(vector_base_addr), .vector_in(vector_in),
    .matrix_enable(matrix_enable), .matrix_addr(matrix_addr), .matrix_data(matrix_data),
    .matrix_ready(matrix_ready), .result_out(result_out), .result_row(result_row),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
    .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int w_m [MR][MC];
  int x_m [MC];
  int rows_cur = 1;
  int cols_cur = 1;
  int mmode = 0;
  int rmode = 0;
  int done_cnt = 0;
  int got_row [$];
  logic [31:0] got_val [$];
  logic [31:0] exp_val [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Matrix memory responder: decodes row/col from the address and fills
  // out-of-range elements with garbage.
  initial begin
    matrix_ready = 1'b0;
    matrix_data  = '0;
    forever begin
      @(negedge clk);
      matrix_ready = (mmode == 0) ? 1'b1 : 1'($urandom % 2);
      for (int l = 0; l < NL; l++) begin
        for (int i = 0; i < BW; i++) begin
          int r, c, v;
          r = int'(matrix_addr) / cols_cur + l;
          c = int'(matrix_addr) % cols_cur + i;
          v = (r < rows_cur && c < cols_cur) ? w_m[r][c] : int'($urandom);
          matrix_data[(l*BW+i)*DW +: DW] = 16'(v);
        end
      end
    end
  end

  // Result consumer: applies backpressure, records handshakes, checks hold.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_out;
    logic [5:0]  prev_row;
    int          cyc;
    prev_stall   = 1'b0;
    prev_out     = '0;
    prev_row     = '0;
    cyc          = 0;
    result_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall && !rst) begin
        check("hold_valid", 64'(result_valid), 64'(1));
        check("hold_out", 64'(result_out), 64'(prev_out));
        check("hold_row", 64'(result_row), 64'(prev_row));
      end
      result_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (result_valid && result_ready) begin
        got_row.push_back(int'(result_row));
        got_val.push_back(result_out);
      end
      prev_stall = result_valid && !result_ready;
      prev_out   = result_out;
      prev_row   = result_row;
      if (done) done_cnt++;
    end
  end

  function automatic void model(input int rows, input int cols, input bit scale);
    longint acc, s, v;
    exp_val.delete();
    for (int r = 0; r < rows; r++) begin
      acc = 0;
      for (int c0 = 0; c0 < cols; c0 += BW) begin
        s = 0;
        for (int c = c0; c < c0 + BW && c < cols; c++) s += longint'(w_m[r][c]) * longint'(x_m[c]);
        acc += s;
        if (acc > 64'sh7FFFFFFF) acc = 64'sh7FFFFFFF;
        if (acc < -64'sh80000000) acc = -64'sh80000000;
      end
      v = acc;
      if (scale) begin
        v = (acc + 2048) >>> FB;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
      end
      exp_val.push_back(32'(v));
    end
  endfunction

  task automatic fill_random();
    for (int r = 0; r < MR; r++)
      for (int c = 0; c < MC; c++) w_m[r][c] = int'($urandom_range(8191)) - 4096;
    for (int c = 0; c < MC; c++) x_m[c] = int'($urandom_range(8191)) - 4096;
  endtask

  task automatic load_vector();
    for (int b = 0; b < MC; b += BW) begin
      @(negedge clk);
      vector_write_enable = 1'b1;
      vector_base_addr    = 6'(b);
      for (int i = 0; i < BW; i++) vector_in[i*DW +: DW] = 16'(x_m[b+i]);
    end
    @(negedge clk);
    vector_write_enable = 1'b0;
  endtask

  task automatic launch(input int rows, input int cols, input bit scale);
    load_vector();
    model(rows, cols, scale);
    got_row.delete();
    got_val.delete();
    done_cnt = 0;
    rows_cur = rows;
    cols_cur = cols;
    @(negedge clk);
    num_rows     = 7'(rows);
    num_cols     = 7'(cols);
    result_scale = scale;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'(1));
  endtask

  task automatic finish_run(input string tag);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 64'(got_val.size()), 64'(exp_val.size()));
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      check({tag, "_row"}, 64'(got_row[i]), 64'(i));
      check({tag, "_val"}, 64'(got_val[i]), 64'(exp_val[i]));
    end
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_men"},  64'(matrix_enable), 64'(0));
    check({tag, "_addr"}, 64'(matrix_addr),   64'(0));
    check({tag, "_out"},  64'(result_out),    64'(0));
    check({tag, "_row"},  64'(result_row),    64'(0));
    check({tag, "_vld"},  64'(result_valid),  64'(0));
    check({tag, "_busy"}, 64'(busy),          64'(0));
    check({tag, "_done"}, 64'(done),          64'(0));
    check({tag, "_cerr"}, 64'(cfg_error),     64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Identity 4x4, x = 1,2,3,4 in Q4.12, rescaled.
    for (int r = 0; r < MR; r++) for (int c = 0; c < MC; c++) w_m[r][c] = 0;
    for (int c = 0; c < MC; c++) x_m[c] = 0;
    for (int k = 0; k < 4; k++) begin
      w_m[k][k] = 4096;
      x_m[k]    = 4096 * (k + 1);
    end
    launch(4, 4, 1'b1);
    finish_run("ident");
    if (got_val.size() == 4) begin
      check("ident_first", 64'(got_val[0]), 64'h1000);
      check("ident_last",  64'(got_val[3]), 64'h4000);
    end

    // Ragged: 3 rows, 20 columns, garbage beyond column 19.
    fill_random();
    launch(3, 20, 1'b0);
    finish_run("ragged");

    // Full-scale saturation.
    for (int r = 0; r < MR; r++) for (int c = 0; c < MC; c++) w_m[r][c] = 32767;
    for (int c = 0; c < MC; c++) x_m[c] = 32767;
    launch(64, 64, 1'b0);
    finish_run("sat_raw");
    if (got_val.size() > 0) check("sat_raw_const", 64'(got_val[0]), 64'h7FFFFFFF);
    launch(64, 64, 1'b1);
    finish_run("sat_scaled");
    if (got_val.size() > 0) check("sat_scaled_const", 64'(got_val[63]), 64'h00007FFF);

    // Backpressure 1-of-3 and random matrix_ready.
    fill_random();
    mmode = 1;
    rmode = 1;
    launch(7, 48, 1'b1);
    finish_run("stall_scaled");
    launch(5, 33, 1'b0);
    finish_run("stall_raw");
    mmode = 0;
    rmode = 0;

    // Rejected configurations.
    @(negedge clk);
    num_rows = 7'd0; num_cols = 7'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_rows0_err",  64'(cfg_error), 64'(1));
    check("cfg_rows0_busy", 64'(busy),      64'(0));
    @(negedge clk);
    check("cfg_err_pulse",  64'(cfg_error), 64'(0));
    num_rows = 7'd4; num_cols = 7'd65; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_cols65_err",  64'(cfg_error), 64'(1));
    check("cfg_cols65_busy", 64'(busy),      64'(0));

    // start and vector writes while busy are ignored.
    fill_random();
    launch(6, 32, 1'b0);
    vector_write_enable = 1'b1;
    vector_base_addr    = 6'd0;
    vector_in           = {8{32'hDEADBEEF}};
    start               = 1'b1;
    num_rows            = 7'd1;
    @(negedge clk);
    vector_write_enable = 1'b0;
    start               = 1'b0;
    finish_run("busy_ignore");

    // Reset during DRAIN, then a clean run.
    fill_random();
    launch(5, 32, 1'b0);
    for (int c = 0; c < 500 && !result_valid; c++) @(negedge clk);
    check("drain_reached", 64'(result_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'(0));
    launch(5, 32, 1'b1);
    finish_run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
